sys_ctrl_tx_queue: RTL and testbench
====================================

// Module: sys_ctrl_tx_queue
// PURPOSE
//  Transmit-side system controller. Collects RF read bytes and multi-byte ALU results.
//  Queues them as bytes in a small FIFO and feeds the UART transmitter one byte per
//  frame using the UART valid/busy handshake. Sits between register file/ALU and UART_TX.
//  Replaces single-slot capture: no result is lost while the UART is busy, up to FIFO_DEPTH.
// PARAMETERS
//  DATA_WIDTH  8  UART frame / RF data width in bits
//  ALU_BYTES   2  ALU result width in DATA_WIDTH units (ALU_OUT = DATA_WIDTH*ALU_BYTES)
//  FIFO_DEPTH  8  byte entries in the queue; power of 2, >= ALU_BYTES
// PORTS
//  CLK            in   1                     system clock
//  RST            in   1                     asynchronous reset, active low
//  RF_RdData      in   DATA_WIDTH            register file read data
//  RF_RdData_VLD  in   1                     RF_RdData valid, 1-cycle pulse
//  ALU_OUT        in   DATA_WIDTH*ALU_BYTES  ALU result
//  ALU_OUT_VLD    in   1                     ALU_OUT valid, 1-cycle pulse
//  UART_TX_Busy   in   1                     UART transmitter is sending a frame
//  ERR_CLR        in   1                     clears OVF_ERR
//  UART_TX_DATA   out  DATA_WIDTH            byte to transmit, held stable between frames
//  UART_TX_VLD    out  1                     1-cycle start pulse to UART
//  FIFO_FULL      out  1                     queue full, registered
//  OVF_ERR        out  1                     sticky: a message was dropped
// BEHAVIOUR
//  Reset values: UART_TX_DATA=0, UART_TX_VLD=0, FIFO_FULL=0, OVF_ERR=0. FIFO is empty,
//   the pending register is empty, and the FSM is in IDLE. Reset mid-frame discards all queued bytes.
//  Ingress:
//   - One FIFO write per cycle max.
//   - A message is RF (1 byte) or ALU (ALU_BYTES bytes, LS byte first).
//   - free = FIFO_DEPTH - count - pend_cnt, where pend_cnt = ALU bytes latched but not yet written.
//   - RF pulse: write the byte this edge if free >= 1 and no pending byte wins the port,
//     otherwise drop it and set OVF_ERR.
//   - ALU pulse: if pend_cnt==0 and free >= ALU_BYTES (+1 if RF is in the same cycle), latch
//     ALU_OUT into the pending shift register and set pend_cnt=ALU_BYTES. Otherwise drop the
//     whole word (never a partial write) and set OVF_ERR.
//   - Write-port priority: pending ALU byte > RF byte. An RF byte arriving while ALU bytes are
//     pending is held in a 1-deep RF skid register and written once pend_cnt reaches 0.
//     A second RF pulse while the skid is occupied is dropped and sets OVF_ERR.
//   - RF and ALU in the same cycle with pend_cnt==0: write the RF byte first, then the ALU bytes
//     on the following edges.
//  Egress FSM (one-hot or binary, 4 states):
//   IDLE       : FIFO non-empty & !UART_TX_Busy -> pop; UART_TX_DATA<=head; UART_TX_VLD<=1 -> SEND
//   SEND       : UART_TX_VLD<=0 -> WAIT_BUSY
//   WAIT_BUSY  : UART_TX_Busy=1 -> WAIT_DONE; otherwise stay
//   WAIT_DONE  : UART_TX_Busy=0 -> IDLE; otherwise stay
//   UART_TX_VLD is high exactly one cycle per byte. UART_TX_DATA changes only on a pop.
//  Latency: an RF pulse sampled at edge k with empty FIFO, IDLE, and Busy low gives
//   UART_TX_VLD=1 after edge k+1 (FIFO write at k, pop at k+1).
//  Simultaneous FIFO push and pop in one cycle is legal at any count, including full.
//   Count is unchanged. The push uses free computed before the pop (conservative).
//  Pointers wrap modulo FIFO_DEPTH. FIFO_FULL = (count==FIFO_DEPTH) after the edge.
//  OVF_ERR: set on any drop and cleared by ERR_CLR. Set wins if both happen in the same cycle.
// STRUCTURE
//  Shared package: FSM state encodings and the clog2-derived PTR_W/CNT_W constants.
//  Sub-module sys_ctrl_tx_fifo: synchronous FIFO with push/pop/full/empty/count,
//   no read latency (head always visible). The top level holds the ingress arbiter,
//   pending shift register, RF skid register, and egress FSM.
// TESTING
//  1 RF 0xA5 pulse, Busy=0 -> VLD pulse 2nd edge after, DATA=0xA5, one pulse only.
//  2 ALU_OUT=0x1234 pulse, UART busy model 10 cycles/frame -> bytes 0x34 then 0x12, two VLD pulses.
//  3 RF 0x55 and ALU 0xBEEF in the same cycle -> order 0x55, 0xEF, 0xBE; OVF_ERR stays 0.
//  4 Busy held 1, push 8 RF bytes 0..7 -> FIFO_FULL=1; 9th RF byte dropped, OVF_ERR=1;
//    release Busy -> 0..7 sent in order.
//  5 FIFO at 7/8, ALU pulse -> whole word dropped, count stays 7, OVF_ERR=1; ERR_CLR -> 0.
//  6 RST low during WAIT_DONE with 3 bytes queued -> all outputs 0, FIFO empty, no VLD after release.

Source files
------------

// File: rtl/sys_ctrl_tx_queue_pkg.sv
// Shared types and sizing helpers for the transmit-side queue.
// FSM encodings and pointer/count widths used by the top and its FIFO.
package sys_ctrl_tx_queue_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ALU_BYTES  = 2;
  localparam int DEF_FIFO_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PTR_W = ptr_w(DEF_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/sys_ctrl_tx_fifo.sv
// Byte FIFO with zero read latency: the head entry is always on dout_o.
// Push and pop may coincide at any fill level, including full.
module sys_ctrl_tx_fifo
  import sys_ctrl_tx_queue_pkg::*;
#(
  parameter int W     = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int PW    = PTR_W,
  parameter int CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/sys_ctrl_tx_queue.sv
// Transmit-side controller: arbitrates RF bytes and ALU words into a byte
// queue and paces them out to the UART with its valid/busy handshake.
module sys_ctrl_tx_queue
  import sys_ctrl_tx_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ALU_BYTES  = DEF_ALU_BYTES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           RF_RdData,
  input  logic                            RF_RdData_VLD,
  input  logic [DATA_WIDTH*ALU_BYTES-1:0] ALU_OUT,
  input  logic                            ALU_OUT_VLD,
  input  logic                            UART_TX_Busy,
  input  logic                            ERR_CLR,
  output logic [DATA_WIDTH-1:0]           UART_TX_DATA,
  output logic                            UART_TX_VLD,
  output logic                            FIFO_FULL,
  output logic                            OVF_ERR
);

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = DATA_WIDTH * ALU_BYTES;
  localparam int PW  = ptr_w(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int PCW = $clog2(ALU_BYTES + 1);

  logic [AW-1:0]  pend_q, pend_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           skid_v_q, skid_v_d;
  logic [DW-1:0]  skid_q, skid_d;
  logic           ovf_q, ovf_d;
  tx_state_e      st_q, st_d;
  logic [DW-1:0]  txd_q, txd_d;
  logic           vld_q, vld_d;

  logic           push, pop;
  logic [DW-1:0]  push_data, head;
  logic           empty, full;
  logic [CW-1:0]  count, free, alu_need;
  logic           port_busy, rf_drop, alu_drop;

  sys_ctrl_tx_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  // Skid and pending bytes already own queue slots, so free excludes them.
  always_comb begin
    free = CW'(FIFO_DEPTH) - count - CW'(pcnt_q) - CW'(skid_v_q);
    alu_need  = CW'(ALU_BYTES) + CW'(RF_RdData_VLD);
    port_busy = (pcnt_q != '0) || skid_v_q;
    pend_d    = pend_q;
    pcnt_d    = pcnt_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    push      = 1'b0;
    push_data = '0;
    rf_drop   = 1'b0;
    alu_drop  = 1'b0;

    if (pcnt_q != '0) begin
      push      = 1'b1;
      push_data = pend_q[DW-1:0];
      pend_d    = pend_q >> DW;
      pcnt_d    = pcnt_q - PCW'(1);
    end else if (skid_v_q) begin
      push      = 1'b1;
      push_data = skid_q;
      skid_v_d  = 1'b0;
    end

    if (RF_RdData_VLD) begin
      if (free == '0) begin
        rf_drop = 1'b1;
      end else if (!port_busy) begin
        push      = 1'b1;
        push_data = RF_RdData;
      end else if (!skid_v_q || pcnt_q == '0) begin
        skid_v_d = 1'b1;
        skid_d   = RF_RdData;
      end else begin
        rf_drop = 1'b1;
      end
    end

    if (ALU_OUT_VLD) begin
      if (pcnt_q == '0 && free >= alu_need) begin
        pend_d = ALU_OUT;
        pcnt_d = PCW'(ALU_BYTES);
      end else begin
        alu_drop = 1'b1;
      end
    end

    if (rf_drop || alu_drop) ovf_d = 1'b1;
    else if (ERR_CLR)        ovf_d = 1'b0;
    else                     ovf_d = ovf_q;
  end

  always_comb begin
    st_d  = st_q;
    txd_d = txd_q;
    vld_d = 1'b0;
    pop   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (!empty && !UART_TX_Busy) begin
          pop   = 1'b1;
          txd_d = head;
          vld_d = 1'b1;
          st_d  = S_SEND;
        end
      end
      S_SEND:      st_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (UART_TX_Busy) st_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!UART_TX_Busy) st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_q   <= '0;
      pcnt_q   <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      ovf_q    <= 1'b0;
      st_q     <= S_IDLE;
      txd_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pcnt_q   <= pcnt_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      ovf_q    <= ovf_d;
      st_q     <= st_d;
      txd_q    <= txd_d;
      vld_q    <= vld_d;
    end
  end

  assign UART_TX_DATA = txd_q;
  assign UART_TX_VLD  = vld_q;
  assign FIFO_FULL    = full;
  assign OVF_ERR      = ovf_q;

endmodule

// File: tb/tb_sys_ctrl_tx_queue.sv
// Directed bench for sys_ctrl_tx_queue with an expected-byte-stream
// model, a UART busy model and a per-cycle output checker.
module tb_sys_ctrl_tx_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        UART_TX_Busy;
  logic        ERR_CLR;
  logic [7:0]  UART_TX_DATA;
  logic        UART_TX_VLD;
  logic        FIFO_FULL;
  logic        OVF_ERR;

  sys_ctrl_tx_queue #(
    .DATA_WIDTH (8),
    .ALU_BYTES  (2),
    .FIFO_DEPTH (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RF_RdData     (RF_RdData),
    .RF_RdData_VLD (RF_RdData_VLD),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VLD   (ALU_OUT_VLD),
    .UART_TX_Busy  (UART_TX_Busy),
    .ERR_CLR       (ERR_CLR),
    .UART_TX_DATA  (UART_TX_DATA),
    .UART_TX_VLD   (UART_TX_VLD),
    .FIFO_FULL     (FIFO_FULL),
    .OVF_ERR       (OVF_ERR)
  );

  always #5 CLK = ~CLK;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_vld   = 0;
  int         frame_cnt = 0;
  logic [7:0] exp_q [$];
  logic       m_ovf = 1'b0;
  logic       hold  = 1'b0;
  logic       prev_vld = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // UART: a frame keeps Busy high for 10 cycles after each start pulse.
  initial begin
    UART_TX_Busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) frame_cnt = 0;
      else begin
        if (frame_cnt > 0) frame_cnt--;
        if (UART_TX_VLD) frame_cnt = 10;
      end
      UART_TX_Busy = hold || (frame_cnt > 0);
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        check("ovf_err", OVF_ERR, m_ovf);
        if (UART_TX_VLD) begin
          n_vld++;
          check("vld_width", prev_vld, 0);
          if (exp_q.size() == 0)
            fail("unexpected_vld", $sformatf("byte 0x%0h", UART_TX_DATA));
          else
            check("tx_data", UART_TX_DATA, exp_q.pop_front());
        end else begin
          check("data_stable", UART_TX_DATA, prev_data);
        end
      end
      prev_vld  = UART_TX_VLD;
      prev_data = UART_TX_DATA;
    end
  end

  task automatic drive(input logic rf, input logic [7:0] rb,
                       input logic rf_ok, input logic alu,
                       input logic [15:0] aw, input logic alu_ok,
                       input logic clr);
    @(negedge CLK);
    RF_RdData_VLD = rf;
    RF_RdData     = rb;
    ALU_OUT_VLD   = alu;
    ALU_OUT       = aw;
    ERR_CLR       = clr;
    if (rf && rf_ok) exp_q.push_back(rb);
    if (alu && alu_ok) begin
      exp_q.push_back(aw[7:0]);
      exp_q.push_back(aw[15:8]);
    end
    if ((rf && !rf_ok) || (alu && !alu_ok)) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge CLK);
    #1;
    RF_RdData_VLD = 1'b0;
    ALU_OUT_VLD   = 1'b0;
    ERR_CLR       = 1'b0;
  endtask

  task automatic rf(input logic [7:0] b, input logic ok);
    drive(1'b1, b, ok, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic alu(input logic [15:0] w, input logic ok);
    drive(1'b0, 8'h0, 1'b1, 1'b1, w, ok, 1'b0);
  endtask

  task automatic clr();
    drive(1'b0, 8'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic drain(input string name);
    int cyc  = 0;
    int quiet = 0;
    while (quiet < 3 && cyc < 600) begin
      @(posedge CLK);
      #2;
      cyc++;
      if (exp_q.size() == 0 && !UART_TX_Busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3)
      fail(name, $sformatf("timeout, %0d bytes outstanding", exp_q.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    RF_RdData = 8'h0;
    RF_RdData_VLD = 1'b0;
    ALU_OUT = 16'h0;
    ALU_OUT_VLD = 1'b0;
    ERR_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_data", UART_TX_DATA, 0);
    check("rst_vld", UART_TX_VLD, 0);
    check("rst_full", FIFO_FULL, 0);
    check("rst_ovf", OVF_ERR, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    rf(8'hA5, 1'b1);
    check("t1_lat_k", UART_TX_VLD, 0);
    @(posedge CLK);
    #1;
    check("t1_lat_k1", UART_TX_VLD, 1);
    check("t1_data", UART_TX_DATA, 8'hA5);
    drain("t1_drain");
    check("t1_pulses", n_vld, 1);

    alu(16'h1234, 1'b1);
    drain("t2_drain");
    check("t2_pulses", n_vld, 3);

    drive(1'b1, 8'h55, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    drain("t3_drain");
    check("t3_ovf", OVF_ERR, 0);
    check("t3_pulses", n_vld, 6);

    alu(16'hBEEF, 1'b1);
    rf(8'h77, 1'b1);
    drain("t3b_drain");
    check("t3b_pulses", n_vld, 9);

    hold = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rf(8'(i), 1'b1);
      check($sformatf("t4_full_%0d", i), FIFO_FULL, (i == 7));
    end
    rf(8'h08, 1'b0);
    check("t4_ovf", OVF_ERR, 1);
    check("t4_full_hold", FIFO_FULL, 1);
    hold = 1'b0;
    drain("t4_drain");
    check("t4_pulses", n_vld, 17);
    clr();
    check("t4_clr", OVF_ERR, 0);

    hold = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 7; i++) rf(8'h10 + 8'(i), 1'b1);
    alu(16'hCAFE, 1'b0);
    check("t5_ovf", OVF_ERR, 1);
    check("t5_full7", FIFO_FULL, 0);
    rf(8'h17, 1'b1);
    check("t5_full8", FIFO_FULL, 1);
    clr();
    check("t5_clr", OVF_ERR, 0);
    hold = 1'b0;
    drain("t5_drain");
    check("t5_pulses", n_vld, 25);

    for (int i = 0; i < 4; i++) rf(8'hD0 + 8'(i), 1'b1);
    repeat (5) @(negedge CLK);
    check("t6_busy", UART_TX_Busy, 1);
    check("t6_queued", exp_q.size(), 3);
    RST = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    #1;
    check("t6_rst_data", UART_TX_DATA, 0);
    check("t6_rst_vld", UART_TX_VLD, 0);
    check("t6_rst_full", FIFO_FULL, 0);
    check("t6_rst_ovf", OVF_ERR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (30) @(negedge CLK);
    check("t6_no_vld", n_vld, 26);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
